key_rotate: RTL
===============

# key_rotate

Sequential DES key-schedule front end. It loads a 64-bit key, applies PC-1, and holds the 28-bit C and D halves in registers. It rotates them once per round according to the DES shift schedule, in either encrypt or decrypt order. Its 56-bit CD output feeds the PC-2 stage (`permute_out`) directly, so one CD value is presented per round and one subkey is produced per handshake.

## Interface
- No parameters; the shift table and PC-1 map are fixed constants.
- `clk` in 1 — system clock, rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `load` in 1 — single-cycle start; captures `key_in` and `decrypt`.
- `key_in` in 64 — DES key; `key_in[63]` is DES bit 1, and parity bits are ignored.
- `decrypt` in 1 — 0 selects encrypt order (K1..K16), 1 selects decrypt order (K16..K1).
- `cd_ready` in 1 — downstream accepts the current `cd_out`.
- `cd_out` out 56 — `{C[27:0], D[27:0]}`; `cd_out[55]` is C bit 1, matching the PC-2 input numbering.
- `cd_valid` out 1 — `cd_out` holds a valid round value.
- `round` out 4 — index of the subkey currently presented, 0..15 (0 = K1 when encrypting, 0 = K16 when decrypting).
- `busy` out 1 — a schedule is in progress.
- `done` out 1 — one-cycle pulse after the 16th value is accepted.

## Operation
- **States:** `IDLE` and `RUN`.
- **Reset:** all of the following are 0: `cd_out`, `cd_valid`, `round`, `busy`, `done`, and the C/D registers. The state is `IDLE`.
- **Shift table (encrypt rounds 1..16):** 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The entries sum to 28.
- **`load` from any state:**
  - Compute C0/D0 = PC-1(`key_in`).
  - Encrypt: register C1D1, i.e. C0/D0 rotated left (toward MSB) by 1.
  - Decrypt: register C16D16, which equals C0D0.
  - Then set `round`=0, `cd_valid`=1, `busy`=1, and enter `RUN`.
- **Load while running:** a `load` during `RUN` aborts the current schedule and restarts; `load` takes priority over a simultaneous handshake.
- **Handshake in `RUN`:** a transfer occurs when `cd_valid`&`cd_ready`.
  - If `round`<15: increment `round` and rotate C and D independently.
    - Encrypt: rotate left by shift[`round`+1] (0-based table index).
    - Decrypt: rotate right by shift[15−`round`].
  - If `round`=15: clear `cd_valid` and `busy`, pulse `done`, and return to `IDLE`.
  - `cd_out` and `round` are cleared to 0 on completion.
- **Backpressure:** with `cd_ready`=0, `cd_out` and `round` hold stable while `cd_valid`=1.
- **Decrypt direction:** `decrypt` is sampled only at `load`; changing it mid-schedule has no effect.
- **Rotations are mod 28 within each half:** left by 1 is `{C[26:0],C[27]}`, right by 1 is `{C[0],C[27:1]}`.
- **Idle behaviour:** in `IDLE`, `cd_ready` is ignored.

## Timing
- `load` sampled at edge N → `cd_valid`=1 with the first CD value after edge N (cycle N+1).
- Handshake at edge M → next CD value visible after M; back-to-back transfers are supported at one per cycle.
- With `cd_ready` held at 1, 16 consecutive values are presented over 16 cycles, and `done` is asserted in the cycle after the last transfer.
- All outputs are registered; there is no combinational path from `key_in` or `cd_ready` to any output.
- Reset asserted mid-schedule clears all outputs immediately, asynchronously.

## Structure
- **Package `des_key_pkg`:**
  - `SHIFT_TABLE[16]` (2-bit entries).
  - The PC-1 index constant array (56 entries).
  - Function `rotl28(x, n)` / `rotr28(x, n)` for n ∈ {1,2}.
- **Sub-module `pc1_permute`:** combinational 64→56 PC-1 mapping, the natural counterpart to `permute_out`.
- **Top level:** the FSM, the 4-bit round counter, and the C/D registers (~150–250 lines).

## Test plan
- **Encrypt first value:** reset, then `load` `key_in`=0x133457799BBCDFF1 with `decrypt`=0 → next cycle `cd_out`=0xE19955FAACCF1E, `round`=0, `cd_valid`=1; PC-2 of it gives K1=0x1B02EFFC7072.
- **Full encrypt run:** same key with `cd_ready`=1 → 16 values, the last (round 15) being 0xF0CCAAF556678F. Every value through PC-2 matches the published K1..K16, and `done` pulses once.
- **Decrypt run:** same key with `decrypt`=1 → first `cd_out`=0xF0CCAAF556678F, second =0xF866557AAB33C7; the sequence is the exact reverse of the encrypt sequence.
- **Backpressure:** toggle `cd_ready` randomly → each of the 16 values is held stable until accepted, none is skipped or duplicated, and `round` increments only on transfers.
- **Abort and reset:** `load` at round 7 with a new key → restarts at `round`=0 with the new C1D1. Asserting `reset` at round 9 clears all outputs to 0 without waiting for a clock edge. `load` coincident with a transfer → restart wins.

Source files
------------

// File: rtl/des_key_pkg.sv
// Constants and helpers for the DES key schedule: per-round shift amounts,
// the PC-1 bit map and the 28-bit half rotations.
package des_key_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    // Left-shift amount for encrypt rounds 1..16. The entries total 28, so C16D16 equals C0D0.
    localparam logic [1:0] SHIFT_TABLE [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC-1 source positions in DES numbering, where bit 1 is key_in[63].
    localparam int PC1_IDX [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/pc1_permute.sv
// Combinational PC-1: selects 56 key bits (parity dropped) into {C0, D0}.
module pc1_permute
    import des_key_pkg::*;
(
    input  logic [63:0] key,
    output logic [55:0] cd
);

    always_comb begin
        cd = '0;
        for (int k = 0; k < 56; k++)
            cd[55-k] = key[64-PC1_IDX[k]];
    end

endmodule

// File: rtl/key_rotate.sv
// DES key-schedule front end: loads a key, applies PC-1, and steps the C/D
// halves through the 16 rounds in encrypt or decrypt order, one per handshake.
module key_rotate
    import des_key_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        cd_ready,
    output logic [55:0] cd_out,
    output logic        cd_valid,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    state_t      state, state_n;
    logic [27:0] c, d, c_n, d_n;
    logic [3:0]  round_n, sidx;
    logic [1:0]  samt;
    logic        valid_n, busy_n, done_n, dec, dec_n;
    logic [55:0] cd0;

    pc1_permute u_pc1 (.key(key_in), .cd(cd0));

    assign cd_out = {c, d};

    // Decrypt walks the table backwards and undoes each shift with a right rotate.
    assign sidx = dec ? (4'd15 - round) : (round + 4'd1);
    assign samt = SHIFT_TABLE[sidx];

    always_comb begin
        state_n = state;
        c_n     = c;
        d_n     = d;
        round_n = round;
        valid_n = cd_valid;
        busy_n  = busy;
        dec_n   = dec;
        done_n  = 1'b0;
        if (load) begin
            c_n     = decrypt ? cd0[55:28] : rotl28(cd0[55:28], 2'd1);
            d_n     = decrypt ? cd0[27:0]  : rotl28(cd0[27:0], 2'd1);
            dec_n   = decrypt;
            round_n = 4'd0;
            valid_n = 1'b1;
            busy_n  = 1'b1;
            state_n = RUN;
        end else if (state == RUN && cd_valid && cd_ready) begin
            if (round == 4'd15) begin
                c_n     = '0;
                d_n     = '0;
                round_n = 4'd0;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end else begin
                round_n = round + 4'd1;
                c_n     = dec ? rotr28(c, samt) : rotl28(c, samt);
                d_n     = dec ? rotr28(d, samt) : rotl28(d, samt);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            c        <= '0;
            d        <= '0;
            round    <= '0;
            cd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dec      <= 1'b0;
        end else begin
            state    <= state_n;
            c        <= c_n;
            d        <= d_n;
            round    <= round_n;
            cd_valid <= valid_n;
            busy     <= busy_n;
            done     <= done_n;
            dec      <= dec_n;
        end
    end

endmodule
